// File: rtl/simon_key_unroll_if.sv
// Handshake bundle for the reverse SIMON round-key generator.
// The master side loads the key and consumes round keys; the slave side is the generator.
// SIMON_KU_PRELOAD_EN adds the preload/tail_key pair for starting straight from k[T-M..T-1].
interface simon_key_unroll_if #(
   parameter int N = 16,
   parameter int M = 4
);
   logic             start;
   logic [N*M-1:0]   key;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     key_o;
   logic [6:0]       rk_idx;
   logic             done;
`ifdef SIMON_KU_PRELOAD_EN
   logic             preload;
   logic [N*M-1:0]   tail_key;

   modport master (
      output start, key, out_ready, preload, tail_key,
      input  busy, out_valid, key_o, rk_idx, done
   );
   modport slave (
      input  start, key, out_ready, preload, tail_key,
      output busy, out_valid, key_o, rk_idx, done
   );
`else
   modport master (
      output start, key, out_ready,
      input  busy, out_valid, key_o, rk_idx, done
   );
   modport slave (
      input  start, key, out_ready,
      output busy, out_valid, key_o, rk_idx, done
   );
`endif
endinterface

// File: rtl/simon_key_unroll.sv
// Reverse SIMON round-key generator for the decrypt datapath.
// Runs the forward key schedule from the master key until the window holds the
// last M round keys, then inverts the recurrence to stream k[T-1] down to k[0].
// Optional feature macro: SIMON_KU_PRELOAD_EN (load k[T-M..T-1] directly, skipping
// the forward phase).
module simon_key_unroll #(
   parameter int N = 16,
   parameter int M = 4,
   parameter int T = 32
) (
   input logic               clk,
   input logic               rst_n,
   simon_key_unroll_if.slave bus
);

   // z sequences, leftmost digit is z[0]
   localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
   localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
   localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
   localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

   // z sequence selection by (N,M) pair
   localparam int ZJ = (N == 16) ? 0 :
                       (N == 24) ? ((M == 3) ? 0 : 1) :
                       (N == 32) ? ((M == 3) ? 2 : 3) :
                       (N == 48) ? ((M == 2) ? 2 : 3) :
                                   ((M == 2) ? 2 : (M == 3) ? 3 : 4);

   localparam logic [61:0] ZSEQ = (ZJ == 0) ? Z0 :
                                  (ZJ == 1) ? Z1 :
                                  (ZJ == 2) ? Z2 :
                                  (ZJ == 3) ? Z3 : Z4;

   localparam logic [N-1:0] C       = ~N'(3);
   localparam logic [6:0]   B_TAIL  = 7'(T - M);
   localparam logic [6:0]   IDX_TOP = 7'(T - 1);

   typedef enum logic [1:0] {
      IDLE,
      FWD,
      REV
   } state_t;

   state_t               state_q;
   logic [M-1:0][N-1:0]  w_q;
   logic [6:0]           b_q;
   logic [6:0]           rk_idx_q;
   logic                 busy_q;
   logic                 out_valid_q;
   logic                 done_q;
   logic [N-1:0]         key_o_q;

   logic [M-1:0][N-1:0]  key_words;
   logic [N-1:0]         fwd_new_d;
   logic [N-1:0]         rev_prev_d;

   // word i of the packed key lands at w[i]
   assign key_words = bus.key;

`ifdef SIMON_KU_PRELOAD_EN
   logic [M-1:0][N-1:0]  tail_words;
   assign tail_words = bus.tail_key;
`endif

   function automatic logic [N-1:0] rotr(input logic [N-1:0] x, input int r);
      return (x >> r) | (x << (N - r));
   endfunction

   function automatic logic [N-1:0] fmix(input logic [N-1:0] x);
      return x ^ rotr(x, 1);
   endfunction

   // z bit at a round index; index is below 124 so one wrap step is enough
   function automatic logic zbit(input logic [6:0] idx);
      logic [5:0] m6;
      m6 = (idx >= 7'd62) ? 6'(idx - 7'd62) : 6'(idx);
      return ZSEQ[6'd61 - m6];
   endfunction

   // next word for one forward step and the recovered word for one reverse step
   always_comb begin
      logic [N-1:0] tf;
      logic [N-1:0] tr;
      tf = rotr(w_q[M-1], 3);
      tr = rotr(w_q[M-2], 3);
      if (M == 4) begin
         tf = tf ^ w_q[1];
         tr = tr ^ w_q[0];
      end
      fwd_new_d  = C ^ {{(N-1){1'b0}}, zbit(b_q)} ^ w_q[0] ^ fmix(tf);
      rev_prev_d = C ^ {{(N-1){1'b0}}, zbit(b_q - 7'd1)} ^ w_q[M-1] ^ fmix(tr);
   end

   // control FSM, key window and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         w_q         <= '0;
         b_q         <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         key_o_q     <= '0;
         rk_idx_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  w_q    <= key_words;
                  b_q    <= '0;
                  busy_q <= 1'b1;
                  if (T == M) begin
                     // master key already is the tail window
                     state_q     <= REV;
                     out_valid_q <= 1'b1;
                     key_o_q     <= key_words[M-1];
                     rk_idx_q    <= IDX_TOP;
                  end else begin
                     state_q <= FWD;
                  end
               end
`ifdef SIMON_KU_PRELOAD_EN
               else if (bus.preload) begin
                  w_q         <= tail_words;
                  b_q         <= B_TAIL;
                  busy_q      <= 1'b1;
                  state_q     <= REV;
                  out_valid_q <= 1'b1;
                  key_o_q     <= tail_words[M-1];
                  rk_idx_q    <= IDX_TOP;
               end
`endif
            end

            FWD: begin
               for (int i = 0; i < M - 1; i++) w_q[i] <= w_q[i+1];
               w_q[M-1] <= fwd_new_d;
               b_q      <= b_q + 7'd1;
               // the step that reaches b=T-M also presents k[T-1]
               if (b_q == B_TAIL - 7'd1) begin
                  state_q     <= REV;
                  out_valid_q <= 1'b1;
                  key_o_q     <= fwd_new_d;
                  rk_idx_q    <= IDX_TOP;
               end
            end

            REV: begin
               if (out_valid_q && bus.out_ready) begin
                  if (rk_idx_q == 7'd0) begin
                     state_q     <= IDLE;
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     key_o_q     <= '0;
                     rk_idx_q    <= '0;
                  end else begin
                     for (int i = M - 1; i > 0; i--) w_q[i] <= w_q[i-1];
                     // below b=0 there is nothing left to recover, the window just drains
                     if (b_q != 7'd0) begin
                        w_q[0] <= rev_prev_d;
                        b_q    <= b_q - 7'd1;
                     end
                     key_o_q  <= w_q[M-2];
                     rk_idx_q <= rk_idx_q - 7'd1;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.done      = done_q;
   assign bus.key_o     = key_o_q;
   assign bus.rk_idx    = rk_idx_q;

endmodule

// File: tb/tb_simon_key_unroll.sv
// Bench for simon_key_unroll: directed SIMON32/64 vector, randomized backpressure,
// ignored-start, mid-run reset and (with SIMON_KU_PRELOAD_EN) preload on a 16/4 instance,
// plus one instance per legal (N,M,T) pair with a random key.
module tb_simon_key_unroll;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   bit   sweep_go = 1'b0;
   logic [9:0] sw_done;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model: plain forward key schedule ----------------
   function automatic logic [63:0] nmask(input int n);
      return (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
   endfunction

   function automatic logic [63:0] ref_rotr(input logic [63:0] x, input int r, input int n);
      logic [63:0] xm;
      xm = x & nmask(n);
      return ((xm >> r) | (xm << (n - r))) & nmask(n);
   endfunction

   function automatic int zsel(input int n, input int m);
      case (n)
         16:      return 0;
         24:      return (m == 3) ? 0 : 1;
         32:      return (m == 3) ? 2 : 3;
         48:      return (m == 2) ? 2 : 3;
         default: return (m == 2) ? 2 : ((m == 3) ? 3 : 4);
      endcase
   endfunction

   function automatic logic ref_z(input int j, input int i);
      string s;
      case (j)
         0:       s = "11111010001001010110000111001101111101000100101011000011100110";
         1:       s = "10001110111110010011000010110101000111011111001001100001011010";
         2:       s = "10101111011100000011010010011000101000010001111110010110110011";
         3:       s = "11011011101011000110010111100000010010001010011100110100001111";
         default: s = "11010001111001101011011000100000010111000011001010010011101111";
      endcase
      return s.getc(i) == 8'd49;
   endfunction

   // k[i+m] from k[i], k[i+1], k[i+m-1]
   function automatic logic [63:0] ref_step(input int n, input int m, input int i,
                                            input logic [63:0] ki, input logic [63:0] ki1,
                                            input logic [63:0] klast);
      logic [63:0] tmp;
      tmp = ref_rotr(klast, 3, n);
      if (m == 4) tmp = tmp ^ ki1;
      tmp = tmp ^ ref_rotr(tmp, 1, n);
      return (~ki ^ tmp ^ {63'd0, ref_z(zsel(n, m), i % 62)} ^ 64'd3) & nmask(n);
   endfunction

   function automatic int cfg_n(input int g);
      case (g)
         0: return 16;  1, 2: return 24;  3, 4: return 32;  5, 6: return 48;  default: return 64;
      endcase
   endfunction
   function automatic int cfg_m(input int g);
      case (g)
         0, 2, 4, 9: return 4;  1, 3, 6, 8: return 3;  default: return 2;
      endcase
   endfunction
   function automatic int cfg_t(input int g);
      case (g)
         0: return 32; 1, 2: return 36; 3: return 42; 4: return 44; 5: return 52;
         6: return 54; 7: return 68; 8: return 69; default: return 72;
      endcase
   endfunction

   // ---------------- main 16/4/32 instance ----------------
   simon_key_unroll_if #(.N(16), .M(4)) mif ();
   simon_key_unroll #(.N(16), .M(4), .T(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mif)
   );

   logic [63:0] mk  [0:31];
   logic [63:0] got [0:31];

   task automatic build_main(input logic [63:0] k);
      for (int i = 0; i < 4; i++) mk[i] = (k >> (16 * i)) & 64'hFFFF;
      for (int i = 0; i < 28; i++) mk[i+4] = ref_step(16, 4, i, mk[i], mk[i+1], mk[i+3]);
   endtask

   // start a run from a negedge, optionally poking start again in FWD cycle poke_cyc
   task automatic launch(input logic [63:0] k, input int poke_cyc, input string tag);
      int cyc;
      build_main(k);
      mif.key   = k;
      mif.start = 1'b1;
      @(negedge clk);
      mif.start = 1'b0;
      chk({tag, "_busy"}, 64'(mif.busy), 64'd1);
      cyc = 1;
      while (!mif.out_valid && cyc < 200) begin
         if (cyc == poke_cyc) begin
            mif.start = 1'b1;
            mif.key   = {$urandom, $urandom};
         end else begin
            mif.start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      mif.start = 1'b0;
      chk({tag, "_lat"}, 64'(cyc), 64'd29);
   endtask

   // consume the reverse stream from a negedge; pct = out_ready probability
   task automatic collect(input int pct, input int poke_at, input int abort_at,
                          input string tag, output bit aborted);
      int          e;
      int          guard;
      bit          held_v;
      logic [22:0] held;
      e = 31; guard = 0; held_v = 1'b0; held = '0; aborted = 1'b0;
      while (e >= 0 && guard < 4000) begin
         mif.start = 1'b0;
         if (held_v) chk({tag, "_hold"}, 64'({mif.key_o, mif.rk_idx}), 64'(held));
         chk({tag, "_nodone"}, 64'(mif.done), 64'd0);
         if (abort_at >= 0 && mif.out_valid && mif.rk_idx == 7'(abort_at)) begin
            rst_n = 1'b0;
            #1;
            chk({tag, "_rst_busy"}, 64'(mif.busy), 64'd0);
            chk({tag, "_rst_vld"},  64'(mif.out_valid), 64'd0);
            chk({tag, "_rst_done"}, 64'(mif.done), 64'd0);
            chk({tag, "_rst_key"},  64'(mif.key_o), 64'd0);
            chk({tag, "_rst_idx"},  64'(mif.rk_idx), 64'd0);
            aborted = 1'b1;
            break;
         end
         mif.out_ready = ($urandom_range(99) < pct);
         if (poke_at >= 0 && (e == poke_at || e == 0)) begin
            mif.start = 1'b1;
            mif.key   = {$urandom, $urandom};
         end
         held_v = mif.out_valid && !mif.out_ready;
         held   = {mif.key_o, mif.rk_idx};
         if (mif.out_valid && mif.out_ready) begin
            chk({tag, "_idx"}, 64'(mif.rk_idx), 64'(e));
            chk({tag, "_key"}, 64'(mif.key_o), mk[e]);
            got[e] = 64'(mif.key_o);
            e--;
         end
         @(negedge clk);
         guard++;
      end
      if (!aborted) begin
         mif.start = 1'b0;
         chk({tag, "_left"}, 64'(e + 1), 64'd0);
         chk({tag, "_done"}, 64'(mif.done), 64'd1);
         chk({tag, "_idle"}, 64'(mif.busy), 64'd0);
         chk({tag, "_vlo"},  64'(mif.out_valid), 64'd0);
         @(negedge clk);
         chk({tag, "_done1"}, 64'(mif.done), 64'd0);
         chk({tag, "_stay"},  64'(mif.busy), 64'd0);
      end
   endtask

   initial begin
      bit          ab;
      int          guard;
      logic [63:0] k1;
      k1 = 64'h1918_1110_0908_0100;
      mif.start = 1'b0; mif.key = '0; mif.out_ready = 1'b0;
`ifdef SIMON_KU_PRELOAD_EN
      mif.preload = 1'b0; mif.tail_key = '0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(mif.busy), 64'd0);
      chk("rst_vld",  64'(mif.out_valid), 64'd0);
      chk("rst_done", 64'(mif.done), 64'd0);
      chk("rst_key",  64'(mif.key_o), 64'd0);
      chk("rst_idx",  64'(mif.rk_idx), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed SIMON32/64 vector, full throughput
      mif.out_ready = 1'b1;
      launch(k1, -1, "t1");
      collect(100, -1, -1, "t1", ab);
      chk("t1_k0", got[0], 64'h0100);
      chk("t1_k1", got[1], 64'h0908);

      // random key with heavy backpressure
      launch({$urandom, $urandom}, -1, "t2");
      collect(30, -1, -1, "t2", ab);

      // start during FWD, during REV and on the final accept are all ignored
      launch({$urandom, $urandom}, 5, "t4");
      collect(100, 20, -1, "t4", ab);
      launch({$urandom, $urandom}, -1, "t4b");
      collect(80, -1, -1, "t4b", ab);

      // reset in the middle of the reverse stream
      launch({$urandom, $urandom}, -1, "t5");
      collect(100, -1, 17, "t5", ab);
      chk("t5_aborted", 64'(ab), 64'd1);
      repeat (3) begin
         @(negedge clk);
         chk("t5_hold_done", 64'(mif.done), 64'd0);
         chk("t5_hold_busy", 64'(mif.busy), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      launch({$urandom, $urandom}, -1, "t5b");
      collect(60, -1, -1, "t5b", ab);

`ifdef SIMON_KU_PRELOAD_EN
      // start wins over preload
      build_main(k1);
      mif.key = k1; mif.tail_key = {$urandom, $urandom};
      mif.start = 1'b1; mif.preload = 1'b1;
      @(negedge clk);
      mif.start = 1'b0; mif.preload = 1'b0;
      chk("t6_prio_busy", 64'(mif.busy), 64'd1);
      chk("t6_prio_vld",  64'(mif.out_valid), 64'd0);
      guard = 0;
      while (!mif.out_valid && guard < 200) begin @(negedge clk); guard++; end
      collect(100, -1, -1, "t6a", ab);
      // preload tail of the directed vector
      mif.tail_key = {mk[31][15:0], mk[30][15:0], mk[29][15:0], mk[28][15:0]};
      mif.preload = 1'b1;
      @(negedge clk);
      mif.preload = 1'b0;
      chk("t6_vld", 64'(mif.out_valid), 64'd1);
      chk("t6_idx", 64'(mif.rk_idx), 64'd31);
      collect(60, -1, -1, "t6", ab);
      chk("t6_k0", got[0], 64'h0100);
`endif

      sweep_go = 1'b1;
      guard = 0;
      while (sw_done !== 10'h3FF && guard < 5000) begin @(negedge clk); guard++; end
      chk("sweep_fin", 64'(sw_done), 64'h3FF);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // ---------------- one instance per legal configuration ----------------
   for (genvar g = 0; g < 10; g++) begin : g_sw
      localparam int GN = cfg_n(g);
      localparam int GM = cfg_m(g);
      localparam int GT = cfg_t(g);

      simon_key_unroll_if #(.N(GN), .M(GM)) sif ();
      simon_key_unroll #(.N(GN), .M(GM), .T(GT)) u_sw (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (sif)
      );

      logic [63:0] gk [0:GT-1];
      bit fin = 1'b0;
      assign sw_done[g] = fin;

      initial begin
         int          e;
         int          guard;
         logic [63:0] m;
         sif.start = 1'b0; sif.key = '0; sif.out_ready = 1'b0;
`ifdef SIMON_KU_PRELOAD_EN
         sif.preload = 1'b0; sif.tail_key = '0;
`endif
         wait (sweep_go);
         @(negedge clk);
         m = nmask(GN);
         for (int i = 0; i < GM; i++) begin
            gk[i] = {$urandom, $urandom} & m;
            sif.key[GN*i +: GN] = gk[i][GN-1:0];
         end
         for (int i = 0; i < GT - GM; i++)
            gk[i+GM] = ref_step(GN, GM, i, gk[i], gk[i+1], gk[i+GM-1]);
         sif.start = 1'b1;
         @(negedge clk);
         sif.start = 1'b0;
         e = GT - 1; guard = 0;
         while (e >= 0 && guard < 3000) begin
            sif.out_ready = ($urandom_range(99) < 50);
            if (sif.out_valid && sif.out_ready) begin
               chk($sformatf("sw%0d_idx", g), 64'(sif.rk_idx), 64'(e));
               chk($sformatf("sw%0d_key", g), 64'(sif.key_o), gk[e]);
               e--;
            end
            @(negedge clk);
            guard++;
         end
         chk($sformatf("sw%0d_left", g), 64'(e + 1), 64'd0);
         chk($sformatf("sw%0d_done", g), 64'(sif.done), 64'd1);
         fin = 1'b1;
      end
   end

endmodule
